// File: rtl/wb_write_arbiter_pkg.sv
// Shared widths, constants and payload types for the writeback write-port arbiter.
// Replaces the defines.v macros for this block with typed package constants.
package wb_write_arbiter_pkg;

    localparam int unsigned REG_NUM_LOG2 = 5;
    localparam int unsigned REG_ADDR_W   = REG_NUM_LOG2;
    localparam int unsigned REG_W        = 32;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic RST_ENABLE_N = 1'b0;

    localparam logic [REG_W-1:0]      ZERO_WORD = '0;
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_data_t;

    // One register-file write: destination and value.
    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

    function automatic logic addr_nonzero(input reg_addr_t a);
        return a != ZERO_ADDR;
    endfunction

endpackage

// File: rtl/wb_mc_fifo.sv
// Ordered buffer for multi-cycle results: per-entry valid/addr/data, with
// parallel address compares used for WAW squash and ID read-hazard detection.
module wb_mc_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [4:0]  push_addr,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        squash,
    input  logic [4:0]  squash_addr,
    input  logic [4:0]  cmp_addr1,
    input  logic [4:0]  cmp_addr2,
    output logic        head_valid_c,
    output logic [4:0]  head_addr_c,
    output logic [31:0] head_data_c,
    output logic        full_c,
    output logic        empty_c,
    output logic        hit1_c,
    output logic        hit2_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    wr_req_t          slot_q [DEPTH];
    wr_req_t          slot_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] match_sq;
    logic [DEPTH-1:0] match_1;
    logic [DEPTH-1:0] match_2;
    logic             push_ok;
    logic             pop_ok;

    // Parallel compare of every live entry against squash and both read ports.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign match_sq[g] = valid_q[g] && (slot_q[g].addr == squash_addr);
        assign match_1[g]  = valid_q[g] && (slot_q[g].addr == cmp_addr1);
        assign match_2[g]  = valid_q[g] && (slot_q[g].addr == cmp_addr2);
    end

    always_comb begin
        full_c       = (count_q == CNT_W'(DEPTH));
        empty_c      = (count_q == '0);
        head_valid_c = valid_q[rd_ptr_q];
        head_addr_c  = slot_q[rd_ptr_q].addr;
        head_data_c  = slot_q[rd_ptr_q].data;
        hit1_c       = |match_1;
        hit2_c       = |match_2;
    end

    // Squash applies to entries already stored; a same-cycle push is newer and survives.
    always_comb begin
        valid_d  = valid_q;
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push & ~full_c;
        pop_ok   = pop & ~empty_c;

        if (squash) begin
            valid_d = valid_q & ~match_sq;
        end
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            slot_d[wr_ptr_q]  = '{addr: push_addr, data: push_data};
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: it is only observed through valid_q.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges the in-order MEM/WB write with buffered multi-cycle results into the
// single regfile write port; pipeline writes win, buffered writes fill free cycles.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        mc_valid,
    input  logic [4:0]  mc_waddr,
    input  logic [31:0] mc_wdata,
    output logic        mc_ready,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic        stallreq,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    logic        issue_wb_c;
    logic        push_c;
    logic        pop_c;
    logic        head_valid_c;
    logic [4:0]  head_addr_c;
    logic [31:0] head_data_c;
    logic        full_c;
    logic        empty_c;
    logic        hit1_c;
    logic        hit2_c;

    logic        we_q, we_d;
    wr_req_t     wr_q, wr_d;

    wb_mc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push_c),
        .push_addr    (mc_waddr),
        .push_data    (mc_wdata),
        .pop          (pop_c),
        .squash       (issue_wb_c),
        .squash_addr  (wb_waddr),
        .cmp_addr1    (raddr1),
        .cmp_addr2    (raddr2),
        .head_valid_c (head_valid_c),
        .head_addr_c  (head_addr_c),
        .head_data_c  (head_data_c),
        .full_c       (full_c),
        .empty_c      (empty_c),
        .hit1_c       (hit1_c),
        .hit2_c       (hit2_c)
    );

    // Handshake, arbitration and hazard; address-0 traffic never occupies the port or buffer.
    always_comb begin
        issue_wb_c = wb_we & addr_nonzero(wb_waddr);
        mc_ready   = rst & ~full_c;
        push_c     = mc_valid & mc_ready & addr_nonzero(mc_waddr);
        pop_c      = ~issue_wb_c & ~empty_c;
        stallreq   = rst & ((re1 & addr_nonzero(raddr1) & hit1_c) |
                            (re2 & addr_nonzero(raddr2) & hit2_c));
    end

    // Next write-port value; a squashed head drains without a write.
    always_comb begin
        we_d = 1'b0;
        wr_d = wr_q;
        if (issue_wb_c) begin
            we_d = WRITE_ENABLE;
            wr_d = '{addr: wb_waddr, data: wb_wdata};
        end else if (pop_c && head_valid_c) begin
            we_d = WRITE_ENABLE;
            wr_d = '{addr: head_addr_c, data: head_data_c};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            we_q <= 1'b0;
            wr_q <= '{addr: ZERO_ADDR, data: ZERO_WORD};
        end else begin
            we_q <= we_d;
            wr_q <= wr_d;
        end
    end

    assign we    = we_q;
    assign waddr = wr_q.addr;
    assign wdata = wr_q.data;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed vector table, reset and
// full-buffer sequences, then random traffic against a queue-based reference model.
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mc_valid;
    logic [4:0]  mc_waddr;
    logic [31:0] mc_wdata;
    logic        mc_ready;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic        stallreq;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .mc_valid (mc_valid),
        .mc_waddr (mc_waddr),
        .mc_wdata (mc_wdata),
        .mc_ready (mc_ready),
        .re1      (re1),
        .raddr1   (raddr1),
        .re2      (re2),
        .raddr2   (raddr2),
        .stallreq (stallreq),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_waddr;
        logic [31:0] wb_wdata;
        logic        mc_valid;
        logic [4:0]  mc_waddr;
        logic [31:0] mc_wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        x_ready;
        logic        x_stall;
        logic        x_we;
        logic [4:0]  x_waddr;
        logic [31:0] x_wdata;
    } vec_t;

    typedef struct {
        bit          v;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    // Reference model: ordered list of pending results plus the write-port registers.
    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          last_acc;

    int n_vec = 0;
    int n_err = 0;

    vec_t tab [23];

    function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic r1, input logic [4:0] ra1,
                                input logic xr, input logic xs,
                                input logic xw, input logic [4:0] xa, input logic [31:0] xd);
        vec_t v;
        v.wb_we = w;  v.wb_waddr = wa; v.wb_wdata = wd;
        v.mc_valid = mv; v.mc_waddr = ma; v.mc_wdata = md;
        v.re1 = r1; v.raddr1 = ra1;
        v.x_ready = xr; v.x_stall = xs;
        v.x_we = xw; v.x_waddr = xa; v.x_wdata = xd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic bit model_ready();
        return (rst == 1'b1) && (q.size() != DEPTH);
    endfunction

    function automatic bit model_stall();
        foreach (q[i]) begin
            if (q[i].v && ((re1 && raddr1 != 5'd0 && q[i].addr == raddr1) ||
                           (re2 && raddr2 != 5'd0 && q[i].addr == raddr2)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_clear();
        q.delete();
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
    endfunction

    // One clock: inputs already driven; starts and ends just after a falling edge.
    task automatic cycle(input bit use_tab, input vec_t v);
        bit   issue;
        bit   acc;
        ent_t e;
        #1;
        chk("mc_ready", 32'(mc_ready), 32'(model_ready()));
        chk("stallreq", 32'(stallreq), 32'(model_stall()));
        if (use_tab) begin
            chk("tab_mc_ready", 32'(mc_ready), 32'(v.x_ready));
            chk("tab_stallreq", 32'(stallreq), 32'(v.x_stall));
        end
        issue = wb_we && (wb_waddr != 5'd0);
        acc   = mc_valid && model_ready();
        if (issue) begin
            foreach (q[i]) if (q[i].addr == wb_waddr) q[i].v = 1'b0;
            m_we = 1'b1; m_waddr = wb_waddr; m_wdata = wb_wdata;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            m_we = e.v;
            if (e.v) begin
                m_waddr = e.addr;
                m_wdata = e.data;
            end
        end else begin
            m_we = 1'b0;
        end
        if (acc && mc_waddr != 5'd0) begin
            e.v = 1'b1; e.addr = mc_waddr; e.data = mc_wdata;
            q.push_back(e);
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("we", 32'(we), 32'(m_we));
        chk("waddr", 32'(waddr), 32'(m_waddr));
        chk("wdata", wdata, m_wdata);
        if (use_tab) begin
            chk("tab_we", 32'(we), 32'(v.x_we));
            chk("tab_waddr", 32'(waddr), 32'(v.x_waddr));
            chk("tab_wdata", wdata, v.x_wdata);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges, held one edge, released on a falling edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_mc_ready", 32'(mc_ready), 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_hold_we", 32'(we), 32'd0);
        chk("rst_hold_mc_ready", 32'(mc_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        wb_we = v.wb_we; wb_waddr = v.wb_waddr; wb_wdata = v.wb_wdata;
        mc_valid = v.mc_valid; mc_waddr = v.mc_waddr; mc_wdata = v.mc_wdata;
        re1 = v.re1; raddr1 = v.raddr1; re2 = 1'b0; raddr2 = 5'd0;
    endtask

    vec_t idle_v;
    bit   pending;

    initial begin
        rst = 1'b0;
        idle_v = mk(0,0,0, 0,0,0, 0,0, 1,0, 0,0,0);
        drive(idle_v);
        model_clear();
        last_acc = 1'b0;

        //                 wb_we wa     wd            mv ma     md      re1 ra1  rdy stl we wa    wd
        tab[0]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 0, 5'd0,  32'h0);
        tab[1]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 1, 5'd5,  32'hDEADBEEF);
        tab[2]  = mk(1, 5'd0, 32'h12345678, 0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 0, 5'd5,  32'hDEADBEEF);
        tab[3]  = mk(1, 5'd1, 32'h101,      1, 5'd7,  32'h11, 0, 5'd0, 1, 0, 1, 5'd1,  32'h101);
        tab[4]  = mk(1, 5'd2, 32'h102,      0, 5'd0,  32'h0,  1, 5'd7, 1, 1, 1, 5'd2,  32'h102);
        tab[5]  = mk(1, 5'd3, 32'h103,      0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 1, 5'd3,  32'h103);
        tab[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 1, 5'd7,  32'h11);
        tab[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 0, 5'd7,  32'h11);
        tab[8]  = mk(1, 5'd4, 32'h201,      1, 5'd10, 32'hA0, 0, 5'd0, 1, 0, 1, 5'd4,  32'h201);
        tab[9]  = mk(1, 5'd4, 32'h202,      1, 5'd11, 32'hB0, 0, 5'd0, 1, 0, 1, 5'd4,  32'h202);
        tab[10] = mk(1, 5'd4, 32'h203,      1, 5'd12, 32'hC0, 0, 5'd0, 0, 0, 1, 5'd4,  32'h203);
        tab[11] = mk(0, 5'd0, 32'h0,        1, 5'd12, 32'hC0, 0, 5'd0, 0, 0, 1, 5'd10, 32'hA0);
        tab[12] = mk(0, 5'd0, 32'h0,        1, 5'd12, 32'hC0, 0, 5'd0, 1, 0, 1, 5'd11, 32'hB0);
        tab[13] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 1, 5'd12, 32'hC0);
        tab[14] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 0, 5'd12, 32'hC0);
        tab[15] = mk(1, 5'd3, 32'h301,      1, 5'd9,  32'h99, 0, 5'd0, 1, 0, 1, 5'd3,  32'h301);
        tab[16] = mk(1, 5'd9, 32'h909,      0, 5'd0,  32'h0,  1, 5'd9, 1, 1, 1, 5'd9,  32'h909);
        tab[17] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  1, 5'd9, 1, 0, 0, 5'd9,  32'h909);
        tab[18] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 0, 5'd9,  32'h909);
        tab[19] = mk(1, 5'd6, 32'h606,      1, 5'd6,  32'h666, 0, 5'd0, 1, 0, 1, 5'd6, 32'h606);
        tab[20] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  1, 5'd6, 1, 1, 1, 5'd6,  32'h666);
        tab[21] = mk(0, 5'd0, 32'h0,        1, 5'd0,  32'h777, 0, 5'd0, 1, 0, 0, 5'd6, 32'h666);
        tab[22] = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  0, 5'd0, 1, 0, 0, 5'd6,  32'h666);

        // Reset held for three edges, then released on a falling edge.
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("init_we", 32'(we), 32'd0);
            chk("init_mc_ready", 32'(mc_ready), 32'd0);
            chk("init_stallreq", 32'(stallreq), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_mc_ready", 32'(mc_ready), 32'd1);

        foreach (tab[i]) begin
            drive(tab[i]);
            cycle(1'b1, tab[i]);
        end

        // Two entries buffered behind pipeline writes, then reset between edges.
        drive(mk(1, 5'd1, 32'hA1, 1, 5'd13, 32'hD13, 0, 5'd0, 0,0,0,0,0));
        cycle(1'b0, idle_v);
        drive(mk(1, 5'd2, 32'hA2, 1, 5'd14, 32'hD14, 0, 5'd0, 0,0,0,0,0));
        cycle(1'b0, idle_v);
        drive(mk(1, 5'd3, 32'hA3, 0, 5'd0, 32'h0, 1, 5'd14, 0,0,0,0,0));
        cycle(1'b0, idle_v);
        chk("pre_rst_stall", 32'(stallreq), 32'd1);
        drive(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd14, 0,0,0,0,0));
        do_reset();
        repeat (4) begin
            cycle(1'b0, idle_v);
            chk("post_rst_no_write", 32'(we), 32'd0);
        end

        // Random traffic over a small address range so collisions are frequent.
        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                pending  = 1'b0;
                mc_valid = 1'b0;
            end
            wb_we    = ($urandom_range(0, 99) < 50);
            wb_waddr = 5'($urandom_range(0, 7));
            wb_wdata = $urandom;
            if (!pending) begin
                mc_valid = ($urandom_range(0, 99) < 45);
                mc_waddr = 5'($urandom_range(0, 7));
                mc_wdata = $urandom;
            end
            re1    = $urandom_range(0, 1) == 1;
            raddr1 = 5'($urandom_range(0, 7));
            re2    = $urandom_range(0, 1) == 1;
            raddr2 = 5'($urandom_range(0, 7));
            cycle(1'b0, idle_v);
            pending = mc_valid && !last_acc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
